// File: rtl/register_file_mp_if.sv
// register_file_mp_if
//   Bus bundle for register_file_mp: two read ports (address in; data and
//   scoreboard busy flag out), two write ports, and the busy-allocation port.
//   Ports:
//     A1, A2       read addresses            RD1, RD2     read data
//     BUSY1, BUSY2 busy flag for A1/A2       WE1, WE2     write enables
//     A3, A4       write addresses           WD1, WD2     write data
//     ALLOC        mark ALLOC_A busy         ALLOC_A      register to mark busy
//   master: the datapath side, which drives addresses and data.
//   slave:  the register file itself.
//   WIDTH and AW must match the WIDTH and $clog2(DEPTH) of the register file
//   that this bundle is connected to.
interface register_file_mp_if #(
  parameter int WIDTH = 32,
  parameter int AW    = 5
);
  logic [AW-1:0]    A1;
  logic [AW-1:0]    A2;
  logic [WIDTH-1:0] RD1;
  logic [WIDTH-1:0] RD2;
  logic             BUSY1;
  logic             BUSY2;
  logic             WE1;
  logic             WE2;
  logic [AW-1:0]    A3;
  logic [AW-1:0]    A4;
  logic [WIDTH-1:0] WD1;
  logic [WIDTH-1:0] WD2;
  logic             ALLOC;
  logic [AW-1:0]    ALLOC_A;

  modport master (
    output A1, A2, WE1, WE2, A3, A4, WD1, WD2, ALLOC, ALLOC_A,
    input  RD1, RD2, BUSY1, BUSY2
  );

  modport slave (
    input  A1, A2, WE1, WE2, A3, A4, WD1, WD2, ALLOC, ALLOC_A,
    output RD1, RD2, BUSY1, BUSY2
  );
endinterface

// File: rtl/register_file_mp.sv
// register_file_mp
//   Multi-port register file: two combinational read ports with same-cycle
//   write bypass, two clocked write ports (port 2 wins on an address clash),
//   an optional hardwired zero register, and a per-register busy scoreboard
//   used by the pipelined core for hazard detection.
//   Ports:
//     clk    clock; all state updates on the rising edge
//     rst_n  synchronous active-low reset; clears storage and busy bits
//     bus    register_file_mp_if.slave (read, write and allocation ports)
//   Parameters:
//     WIDTH     data width of each register
//     DEPTH     number of registers (power of two, >= 2)
//     ZERO_REG  1: register 0 reads as 0, is never written, never busy
module register_file_mp #(
  parameter int WIDTH    = 32,
  parameter int DEPTH    = 32,
  parameter int ZERO_REG = 1,
  localparam int AW      = $clog2(DEPTH)
) (
  input logic               clk,
  input logic               rst_n,
  register_file_mp_if.slave bus
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [DEPTH-1:0] busy_q;
  logic [DEPTH-1:0] busy_d;

  logic wr1_ok;
  logic wr2_ok;
  logic alloc_ok;

  function automatic logic is_zero(input logic [AW-1:0] addr);
    return (ZERO_REG != 0) && (addr == '0);
  endfunction

  assign wr1_ok   = bus.WE1   && !is_zero(bus.A3);
  assign wr2_ok   = bus.WE2   && !is_zero(bus.A4);
  assign alloc_ok = bus.ALLOC && !is_zero(bus.ALLOC_A);

  // Port 2 is applied after port 1 so it wins a same-address clash. The
  // allocation is applied last: a new producer issuing in the same cycle as
  // a retiring write to that register leaves the register busy.
  always_comb begin
    mem_d  = mem_q;
    busy_d = busy_q;
    if (wr1_ok) begin
      mem_d[bus.A3]  = bus.WD1;
      busy_d[bus.A3] = 1'b0;
    end
    if (wr2_ok) begin
      mem_d[bus.A4]  = bus.WD2;
      busy_d[bus.A4] = 1'b0;
    end
    if (alloc_ok) begin
      busy_d[bus.ALLOC_A] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      busy_q <= '0;
    end else begin
      mem_q  <= mem_d;
      busy_q <= busy_d;
    end
  end

  // Read ports. A write presented this cycle is forwarded to a matching
  // read and also hides the busy bit, since the producer is retiring now.
  // Bypass and outputs are suppressed while reset is held.
  for (genvar p = 0; p < 2; p++) begin : g_rd
    logic [AW-1:0]    addr;
    logic             hit1;
    logic             hit2;
    logic [WIDTH-1:0] data;
    logic             busy;

    assign addr = (p == 0) ? bus.A1 : bus.A2;
    assign hit1 = bus.WE1 && (bus.A3 == addr);
    assign hit2 = bus.WE2 && (bus.A4 == addr);

    always_comb begin
      data = mem_q[addr];
      busy = busy_q[addr] && !(hit1 || hit2);
      if (hit2) begin
        data = bus.WD2;
      end else if (hit1) begin
        data = bus.WD1;
      end
      if (!rst_n || is_zero(addr)) begin
        data = '0;
        busy = 1'b0;
      end
    end
  end

  assign bus.RD1   = g_rd[0].data;
  assign bus.RD2   = g_rd[1].data;
  assign bus.BUSY1 = g_rd[0].busy;
  assign bus.BUSY2 = g_rd[1].busy;

endmodule
